// File: rtl/up_down_counter.sv
// Up/down counter with one-cycle overflow/underflow pulses and a synchronous active-low reset.
// Define UP_DOWN_COUNTER_SATURATE_EN to clamp at the range ends instead of wrapping.
module up_down_counter #(
    parameter int unsigned WIDTH = 3,
    parameter int unsigned INIT  = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             up,
    input  logic             down,
    output logic [WIDTH-1:0] count,
    output logic             at_max,
    output logic             at_min,
    output logic             overflow,
    output logic             underflow
);

    localparam logic [WIDTH-1:0] MAX_C  = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] MIN_C  = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE_C  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] INIT_C = WIDTH'(INIT);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic             overflow_q;
    logic             overflow_d;
    logic             underflow_q;
    logic             underflow_d;
    logic             at_max_s;
    logic             at_min_s;

    // Range-end decode of the current count
    always_comb begin
        at_max_s = (count_q == MAX_C);
        at_min_s = (count_q == MIN_C);
    end

    // Next-state: both or neither request means hold; a step off either end raises a flag
    always_comb begin
        count_d     = count_q;
        overflow_d  = 1'b0;
        underflow_d = 1'b0;
        case ({up, down})
            2'b10: begin
                if (at_max_s) begin
                    overflow_d = 1'b1;
`ifdef UP_DOWN_COUNTER_SATURATE_EN
                    count_d    = MAX_C;
`else
                    count_d    = MIN_C;
`endif
                end else begin
                    count_d = count_q + ONE_C;
                end
            end
            2'b01: begin
                if (at_min_s) begin
                    underflow_d = 1'b1;
`ifdef UP_DOWN_COUNTER_SATURATE_EN
                    count_d     = MIN_C;
`else
                    count_d     = MAX_C;
`endif
                end else begin
                    count_d = count_q - ONE_C;
                end
            end
            default: begin
                count_d     = count_q;
                overflow_d  = 1'b0;
                underflow_d = 1'b0;
            end
        endcase
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            count_q     <= INIT_C;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign count     = count_q;
    assign at_max    = at_max_s;
    assign at_min    = at_min_s;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

endmodule

// File: tb/tb_up_down_counter.sv
// Bench for up_down_counter (WIDTH=3, INIT=0): directed vector table, a reset-priority
// sequence, then random stimulus against an arithmetic reference model.
module tb_up_down_counter;

    localparam int W   = 3;
    localparam int MAX = (1 << W) - 1;
`ifdef UP_DOWN_COUNTER_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic         clk;
    logic         reset;
    logic         up;
    logic         down;
    logic [W-1:0] count;
    logic         at_max;
    logic         at_min;
    logic         overflow;
    logic         underflow;

    int errors = 0;
    int checks = 0;

    // reference model state
    int m_count = 0;
    bit m_ovf   = 1'b0;
    bit m_unf   = 1'b0;

    typedef struct {
        bit r;
        bit u;
        bit d;
        int cnt;
        bit ovf;
        bit unf;
    } vec_t;

    vec_t vecs[$];

    up_down_counter #(.WIDTH(W), .INIT(0)) dut (
        .clk       (clk),
        .reset     (reset),
        .up        (up),
        .down      (down),
        .count     (count),
        .at_max    (at_max),
        .at_min    (at_min),
        .overflow  (overflow),
        .underflow (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_step(input bit r, input bit u, input bit d);
        if (!r) begin
            m_count = 0;
            m_ovf   = 1'b0;
            m_unf   = 1'b0;
        end else if (u && !d) begin
            m_ovf   = (m_count == MAX);
            m_unf   = 1'b0;
            m_count = SAT ? ((m_count + 1 > MAX) ? MAX : m_count + 1) : (m_count + 1) % (MAX + 1);
        end else if (d && !u) begin
            m_unf   = (m_count == 0);
            m_ovf   = 1'b0;
            m_count = SAT ? ((m_count - 1 < 0) ? 0 : m_count - 1) : (m_count + MAX) % (MAX + 1);
        end else begin
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end
    endtask

    // Apply one cycle of inputs, then sample just after the edge
    task automatic step(input bit r, input bit u, input bit d);
        reset = r;
        up    = u;
        down  = d;
        model_step(r, u, d);
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input int cnt, input bit ovf, input bit unf);
        check({tag, ".count"},     int'(count),     cnt);
        check({tag, ".at_max"},    int'(at_max),    int'(cnt == MAX));
        check({tag, ".at_min"},    int'(at_min),    int'(cnt == 0));
        check({tag, ".overflow"},  int'(overflow),  int'(ovf));
        check({tag, ".underflow"}, int'(underflow), int'(unf));
    endtask

    task automatic add(input bit r, input bit u, input bit d, input int cnt, input bit ovf, input bit unf);
        vec_t v;
        v.r = r; v.u = u; v.d = d; v.cnt = cnt; v.ovf = ovf; v.unf = unf;
        vecs.push_back(v);
    endtask

    initial begin
        reset = 1'b0;
        up    = 1'b0;
        down  = 1'b0;

        // reset with up held, count up/down, underflow at zero
        add(1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b0);
        add(1'b1, 1'b1, 1'b0, 1, 1'b0, 1'b0);
        add(1'b1, 1'b1, 1'b0, 2, 1'b0, 1'b0);
        add(1'b1, 1'b0, 1'b1, 1, 1'b0, 1'b0);
        add(1'b1, 1'b0, 1'b1, 0, 1'b0, 1'b0);
        add(1'b1, 1'b0, 1'b1, SAT ? 0 : 7, 1'b0, 1'b1);
        add(1'b1, 1'b0, 1'b1, SAT ? 0 : 6, 1'b0, SAT);
        add(1'b1, 1'b0, 1'b0, SAT ? 0 : 6, 1'b0, 1'b0);
        // back to zero, climb to 5, hold with both requests
        add(1'b0, 1'b0, 1'b1, 0, 1'b0, 1'b0);
        for (int i = 1; i <= 5; i++) add(1'b1, 1'b1, 1'b0, i, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++)  add(1'b1, 1'b1, 1'b1, 5, 1'b0, 1'b0);
        add(1'b1, 1'b0, 1'b0, 5, 1'b0, 1'b0);
        // climb through the top
        add(1'b1, 1'b1, 1'b0, 6, 1'b0, 1'b0);
        add(1'b1, 1'b1, 1'b0, 7, 1'b0, 1'b0);
        add(1'b1, 1'b1, 1'b0, SAT ? 7 : 0, 1'b1, 1'b0);
        add(1'b1, 1'b1, 1'b0, SAT ? 7 : 1, SAT, 1'b0);
        add(1'b1, 1'b0, 1'b0, SAT ? 7 : 1, 1'b0, 1'b0);

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].r, vecs[i].u, vecs[i].d);
            check_all($sformatf("vec%0d", i), vecs[i].cnt, vecs[i].ovf, vecs[i].unf);
        end

        // reset mid-count with up held: INIT next edge, then resume
        step(1'b0, 1'b0, 1'b0);
        for (int i = 1; i <= 4; i++) step(1'b1, 1'b1, 1'b0);
        check_all("seq.at4", 4, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        check_all("seq.rst", 0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        check_all("seq.resume", 1, 1'b0, 1'b0);

        // random stimulus against the model
        for (int i = 0; i < 400; i++) begin
            bit r;
            r = ($urandom_range(0, 19) != 0);
            step(r, 1'(($urandom >> 3) & 1), 1'(($urandom >> 5) & 1));
            check_all($sformatf("rnd%0d", i), m_count, m_ovf, m_unf);
            check("rnd.exclusive", int'(overflow && underflow), 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
